positron_layer_ctrl: RTL and testbench
======================================

POSITRON_LAYER_CTRL -- requirements
Module: positron_layer_ctrl

Interface
REQ-001 SHALL have parameter POSIT_WIDTH, default 4, meaning width of every posit word.
REQ-002 SHALL have parameter NB_INPUTS, default 784, meaning activations per window (beats per input window).
REQ-003 SHALL have parameter NB_NEURONS, default 16, meaning number of positrons in the layer (NB_NEURONS >= 2).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have upstream ports rts_i (in, 1), rtr_o (out, 1), sow_i (in, 1), eow_i (in, 1), posit_i (in, POSIT_WIDTH): activation stream.
REQ-007 SHALL have broadcast ports pe_rts_o (out, 1), pe_sow_o (out, 1), pe_eow_o (out, 1), pe_posit_o (out, POSIT_WIDTH), pe_rtr_i (in, NB_NEURONS): one rtr bit per positron.
REQ-008 SHALL have collect ports pe_done_i (in, NB_NEURONS), each positron's rts_o; pe_posit_i (in, NB_NEURONS*POSIT_WIDTH), neuron k at bits [k*POSIT_WIDTH +: POSIT_WIDTH]; pe_ack_o (out, NB_NEURONS), each positron's rtr_i.
REQ-009 SHALL have downstream ports rts_o (out, 1), rtr_i (in, 1), sow_o (out, 1), eow_o (out, 1), posit_o (out, POSIT_WIDTH).
REQ-010 SHALL have status ports busy_o (out, 1), high when state != IDLE; err_o (out, 1), sticky framing error.

Function
REQ-011 SHALL implement FSM states IDLE, STREAM, DRAIN, COLLECT.
REQ-012 rtr_o SHALL equal (state==IDLE or STREAM) AND all bits of pe_rtr_i high; 0 in DRAIN and COLLECT.
REQ-013 Upstream transfer SHALL be rts_i & rtr_o.
REQ-014 pe_rts_o SHALL equal transfer AND (state==STREAM OR sow_i); pe_posit_o = posit_i; combinational pass-through, zero latency.
REQ-015 IDLE: transfer with sow_i -> forward with pe_sow_o=1, beat counter := 1, go STREAM; transfer without sow_i -> beat dropped (pe_rts_o=0), err_o set, stay IDLE.
REQ-016 STREAM: each transfer increments beat counter (width clog2(NB_INPUTS+1)); pe_sow_o=0.
REQ-017 pe_eow_o SHALL be asserted on the forwarded beat whose index equals NB_INPUTS, regardless of eow_i; the FSM goes to DRAIN after that beat.
REQ-018 eow_i on a beat with index != NB_INPUTS, missing eow_i on beat NB_INPUTS, or sow_i in STREAM SHALL set err_o; the beat is forwarded as normal data.
REQ-019 DRAIN: wait until all pe_done_i bits are high, then go COLLECT with neuron index := 0; pe_ack_o = 0 in DRAIN.
REQ-020 COLLECT: rts_o=1, posit_o = pe_posit_i slice[index], sow_o = (index==0), eow_o = (index==NB_NEURONS-1); rts_o=0 in all other states.
REQ-021 On rts_o & rtr_i, pe_ack_o[index] SHALL pulse for that cycle only and index SHALL increment; other pe_ack_o bits stay 0.
REQ-022 Handshake with index==NB_NEURONS-1 SHALL return the FSM to IDLE; the next window may be accepted the following cycle.
REQ-023 Output order SHALL be fixed ascending neuron index; outputs SHALL hold stable while rtr_i is low.
REQ-024 err_o SHALL clear only on reset.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, beat counter=0, index=0, err_o=0, and rts_o, sow_o, eow_o, pe_ack_o, busy_o low; rtr_o and pe_rts_o follow REQ-012/014 combinationally.
REQ-026 Reset mid-window SHALL abandon the window; no partial output SHALL be emitted after release.

Verification (NB_INPUTS=4, NB_NEURONS=3, POSIT_WIDTH=4)
REQ-027 Nominal: beats 1,2,3,4 with sow on beat 1 and eow on beat 4, pe_rtr_i=3'b111; pe_done_i=111 with pe_posit_i={C,B,A} -> pe_rts_o 4 pulses, pe_eow_o on beat 4; posit_o A,B,C, sow_o on A, eow_o on C, pe_ack_o 001,010,100.
REQ-028 Backpressure: pe_rtr_i=3'b101 for 2 cycles mid-window -> rtr_o=0, no pe_rts_o, counter frozen; resume gives exactly 4 forwarded beats.
REQ-029 Downstream stall: rtr_i=0 for 3 cycles in COLLECT -> posit_o, sow_o, and pe_ack_o=000 held; no index advance.
REQ-030 Framing: eow_i on beat 2 -> err_o=1 and stays 1; pe_eow_o still only on beat 4; non-sow beat in IDLE -> dropped, err_o=1.
REQ-031 Drain wait: pe_done_i=011 for 5 cycles then 111 -> rts_o low until the cycle after 111.
REQ-032 Reset in COLLECT after first output -> busy_o=0, rts_o=0 immediately; a fresh window then yields a full 3-word output starting with sow_o.

Source files
------------

// File: rtl/positron_layer_ctrl.sv
// Layer sequencer for a bank of positrons: forwards one activation window to all of them,
// waits until every positron has a result, then streams the results out in ascending neuron order.
module positron_layer_ctrl #(
    parameter int POSIT_WIDTH = 4,
    parameter int NB_INPUTS   = 784,
    parameter int NB_NEURONS  = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // upstream activation stream
    input  logic                              rts_i,
    output logic                              rtr_o,
    input  logic                              sow_i,
    input  logic                              eow_i,
    input  logic [POSIT_WIDTH-1:0]            posit_i,
    // broadcast to positrons
    output logic                              pe_rts_o,
    output logic                              pe_sow_o,
    output logic                              pe_eow_o,
    output logic [POSIT_WIDTH-1:0]            pe_posit_o,
    input  logic [NB_NEURONS-1:0]             pe_rtr_i,
    // collect from positrons
    input  logic [NB_NEURONS-1:0]             pe_done_i,
    input  logic [NB_NEURONS*POSIT_WIDTH-1:0] pe_posit_i,
    output logic [NB_NEURONS-1:0]             pe_ack_o,
    // downstream result stream
    output logic                              rts_o,
    input  logic                              rtr_i,
    output logic                              sow_o,
    output logic                              eow_o,
    output logic [POSIT_WIDTH-1:0]            posit_o,
    // status
    output logic                              busy_o,
    output logic                              err_o
);

    localparam int CW = $clog2(NB_INPUTS + 1);
    localparam int IW = $clog2(NB_NEURONS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NB_INPUTS);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NB_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, COLLECT} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_beat_cnt;
    logic [CW-1:0]          w_beat_idx;
    logic [IW-1:0]          r_idx;
    logic                   r_err;
    logic                   w_xfer;
    logic                   w_fwd;
    logic                   w_last_beat;
    logic                   w_all_done;
    logic                   w_hs;
    logic                   w_frame_err;
    logic [POSIT_WIDTH-1:0] w_slot [NB_NEURONS];

    for (genvar k = 0; k < NB_NEURONS; k++) begin : g_slot
        assign w_slot[k] = pe_posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
    end

    // Index the current beat would take if forwarded; a window always starts at 1.
    assign w_beat_idx  = (r_state == STREAM) ? r_beat_cnt + 1'b1 : CW'(1);
    assign w_last_beat = (w_beat_idx == LAST_BEAT);
    assign w_all_done  = &pe_done_i;

    assign rtr_o  = ((r_state == IDLE) || (r_state == STREAM)) && (&pe_rtr_i);
    assign w_xfer = rts_i & rtr_o;
    assign w_fwd  = w_xfer & ((r_state == STREAM) | sow_i);
    assign w_hs   = (r_state == COLLECT) & rtr_i;

    // Framing violations: stray beat in IDLE, eow disagreeing with the beat count, sow mid-window.
    assign w_frame_err = (w_xfer & (r_state == IDLE) & ~sow_i)
                       | (w_fwd & ((eow_i != w_last_beat) | ((r_state == STREAM) & sow_i)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_fwd) w_next = w_last_beat ? DRAIN : STREAM;
            STREAM:  if (w_fwd && w_last_beat) w_next = DRAIN;
            DRAIN:   if (w_all_done) w_next = COLLECT;
            COLLECT: if (w_hs && (r_idx == LAST_IDX)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_idx      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_fwd)
                r_beat_cnt <= w_beat_idx;
            if ((r_state == DRAIN) && w_all_done)
                r_idx <= '0;
            else if (w_hs)
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            if (w_frame_err)
                r_err <= 1'b1;
        end
    end

    always_comb begin
        pe_rts_o   = w_fwd;
        pe_sow_o   = w_fwd & (r_state == IDLE);
        pe_eow_o   = w_fwd & w_last_beat;
        pe_posit_o = posit_i;
        busy_o     = (r_state != IDLE);
        err_o      = r_err;
        rts_o      = 1'b0;
        sow_o      = 1'b0;
        eow_o      = 1'b0;
        posit_o    = '0;
        pe_ack_o   = '0;
        if (r_state == COLLECT) begin
            rts_o   = 1'b1;
            posit_o = w_slot[r_idx];
            sow_o   = (r_idx == '0);
            eow_o   = (r_idx == LAST_IDX);
            for (int k = 0; k < NB_NEURONS; k++)
                pe_ack_o[k] = w_hs && (r_idx == IW'(k));
        end
    end

endmodule

// File: tb/tb_positron_layer_ctrl.sv
// Directed bench for positron_layer_ctrl with NB_INPUTS=4, NB_NEURONS=3, POSIT_WIDTH=4.
module tb_positron_layer_ctrl;
    localparam int PW = 4;
    localparam int NI = 4;
    localparam int NN = 3;

    logic           clk, rst_n;
    logic           rts_i, rtr_o, sow_i, eow_i;
    logic [PW-1:0]  posit_i;
    logic           pe_rts_o, pe_sow_o, pe_eow_o;
    logic [PW-1:0]  pe_posit_o;
    logic [NN-1:0]  pe_rtr_i, pe_done_i, pe_ack_o;
    logic [NN*PW-1:0] pe_posit_i;
    logic           rts_o, rtr_i, sow_o, eow_o;
    logic [PW-1:0]  posit_o;
    logic           busy_o, err_o;

    int n_chk  = 0;
    int n_fail = 0;
    int fwd_cnt = 0;
    int eow_at  = 0;
    logic [PW-1:0] exp_w [NN] = '{4'hA, 4'hB, 4'hC};

    positron_layer_ctrl #(.POSIT_WIDTH(PW), .NB_INPUTS(NI), .NB_NEURONS(NN)) dut (
        .clk(clk), .rst_n(rst_n),
        .rts_i(rts_i), .rtr_o(rtr_o), .sow_i(sow_i), .eow_i(eow_i), .posit_i(posit_i),
        .pe_rts_o(pe_rts_o), .pe_sow_o(pe_sow_o), .pe_eow_o(pe_eow_o),
        .pe_posit_o(pe_posit_o), .pe_rtr_i(pe_rtr_i),
        .pe_done_i(pe_done_i), .pe_posit_i(pe_posit_i), .pe_ack_o(pe_ack_o),
        .rts_o(rts_o), .rtr_i(rtr_i), .sow_o(sow_o), .eow_o(eow_o), .posit_o(posit_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts beats actually forwarded to the positrons in the current window.
    always @(posedge clk) begin
        if (pe_rts_o) begin
            fwd_cnt = fwd_cnt + 1;
            if (pe_eow_o) eow_at = fwd_cnt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rts_i = 0; sow_i = 0; eow_i = 0; posit_i = '0;
        pe_rtr_i = '1; pe_done_i = '0; rtr_i = 0;
        pe_posit_i = {4'hC, 4'hB, 4'hA};
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Drives one 4-beat window; eow_mask bit b-1 sets eow_i on beat b; bp_at stalls 2 cycles before that beat.
    task automatic send_window(input logic [3:0] eow_mask, input int bp_at);
        fwd_cnt = 0; eow_at = 0;
        for (int b = 1; b <= NI; b++) begin
            rts_i = 1; posit_i = PW'(b); sow_i = (b == 1); eow_i = eow_mask[b-1];
            if (b == bp_at) begin
                pe_rtr_i = 3'b101;
                repeat (2) begin
                    #1;
                    chk("bp_rtr_o", rtr_o, 0);
                    chk("bp_pe_rts", pe_rts_o, 0);
                    tick();
                end
                pe_rtr_i = 3'b111;
            end
            #1;
            chk("pe_rts", pe_rts_o, 1);
            chk("pe_sow", pe_sow_o, (b == 1));
            chk("pe_eow", pe_eow_o, (b == NI));
            chk("pe_posit", pe_posit_o, b);
            tick();
        end
        rts_i = 0; sow_i = 0; eow_i = 0;
        chk("fwd_cnt", fwd_cnt, NI);
        chk("eow_at", eow_at, NI);
        chk("drain_rtr_o", rtr_o, 0);
        chk("drain_busy", busy_o, 1);
    endtask

    task automatic collect(input int drain_wait, input int stall);
        pe_done_i = 3'b011;
        repeat (drain_wait) begin
            #1;
            chk("drain_rts", rts_o, 0);
            tick();
        end
        pe_done_i = 3'b111;
        #1;
        chk("drain_last_rts", rts_o, 0);
        chk("drain_ack", pe_ack_o, 0);
        tick();
        pe_done_i = 3'b000;
        rtr_i = 0;
        repeat (stall) begin
            #1;
            chk("stall_rts", rts_o, 1);
            chk("stall_posit", posit_o, 4'hA);
            chk("stall_sow", sow_o, 1);
            chk("stall_ack", pe_ack_o, 0);
            tick();
        end
        rtr_i = 1;
        for (int k = 0; k < NN; k++) begin
            #1;
            chk("col_rts", rts_o, 1);
            chk("col_posit", posit_o, exp_w[k]);
            chk("col_sow", sow_o, (k == 0));
            chk("col_eow", eow_o, (k == NN - 1));
            chk("col_ack", pe_ack_o, 32'(1) << k);
            tick();
        end
        rtr_i = 0;
        chk("done_busy", busy_o, 0);
        chk("done_rts", rts_o, 0);
    endtask

    initial begin
        rst_n = 1'b0; rts_i = 0; sow_i = 0; eow_i = 0; posit_i = '0;
        pe_rtr_i = '1; pe_done_i = '0; rtr_i = 0; pe_posit_i = {4'hC, 4'hB, 4'hA};
        #3;
        chk("rst_busy", busy_o, 0);
        chk("rst_rts", rts_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ack", pe_ack_o, 0);
        chk("rst_rtr_o", rtr_o, 1);
        do_reset();

        // nominal window
        send_window(4'b1000, 0);
        collect(0, 0);
        chk("nom_err", err_o, 0);

        // upstream backpressure, drain wait and downstream stall
        send_window(4'b1000, 3);
        collect(5, 3);
        chk("bp_err", err_o, 0);

        // reset while collecting, after the first word
        send_window(4'b1000, 0);
        pe_done_i = 3'b111;
        tick();
        pe_done_i = 3'b000;
        rtr_i = 1;
        #1;
        chk("mid_posit0", posit_o, 4'hA);
        chk("mid_ack0", pe_ack_o, 3'b001);
        tick();
        rtr_i = 0;
        chk("mid_posit1", posit_o, 4'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_rts", rts_o, 0);
        chk("mid_rst_ack", pe_ack_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_rts", rts_o, 0);
        chk("post_rst_busy", busy_o, 0);
        send_window(4'b1000, 0);
        collect(0, 0);
        chk("post_rst_err", err_o, 0);

        // eow on beat 2 is a framing error; pe_eow still only on beat 4
        send_window(4'b1010, 0);
        chk("frm_err", err_o, 1);
        collect(0, 0);
        chk("frm_err_sticky", err_o, 1);

        // non-sow beat in IDLE is dropped and flagged
        do_reset();
        chk("idle_err0", err_o, 0);
        rts_i = 1; sow_i = 0; posit_i = 4'h7;
        #1;
        chk("idle_rtr_o", rtr_o, 1);
        chk("idle_drop", pe_rts_o, 0);
        tick();
        rts_i = 0;
        chk("idle_err", err_o, 1);
        chk("idle_busy", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
